pong_match_ctrl: RTL and testbench
==================================

# pong_match_ctrl

Match-flow controller for the Pong game. Sequences a match through idle, serve countdown, live play, point pause and game-over. Owns both player scores. Drives the run/recenter controls of the ball/paddle pixel generator, so that block no longer keeps game state itself. Sits between the debounced button inputs and the pixel generator, and advances on the 60 Hz frame tick.

## Interface
Parameters:
- WIN_SCORE, 8: score that ends the match; legal range 1..15.
- SERVE_FRAMES, 120: frame ticks spent in the serve countdown; must be a multiple of 3 and ≥ 3.
- POINT_FRAMES, 60: frame ticks of pause after a point; must be ≥ 1.

Ports:
- clk, in, 1: system clock (pixel clock domain).
- reset_n, in, 1: asynchronous, active-low reset.
- frame_tick, in, 1: one-cycle pulse per video frame (start of vertical retrace).
- start_btn, in, 1: start button level, already synchronized and debounced.
- pause_btn, in, 1: pause button level, already synchronized and debounced.
- goal_r, in, 1: one-cycle pulse; ball left through the right edge, so player 1 (left paddle) scores.
- goal_l, in, 1: one-cycle pulse; ball left through the left edge, so player 2 (right paddle) scores.
- ball_run, out, 1: 1 = ball moves and is drawn.
- ball_reset, out, 1: one-cycle pulse; pixel generator recenters the ball.
- serve_dir, out, 1: initial ball x direction; 1 = rightward, 0 = leftward.
- score1, out, 4: player 1 score.
- score2, out, 4: player 2 score.
- game_over, out, 1: match finished.
- countdown, out, 2: serve countdown digit (3, 2, 1); 0 outside SERVE.
- state, out, 3: current state encoding, used for debug and HUD.

## Operation
- State encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSE=5 (PAUSE only with the macro).
- Edge detection:
  - start_rise = start_btn & ~start_q; pause_rise = pause_btn & ~pause_q.
  - start_q and pause_q are registered copies of the buttons, reset to 0.
- IDLE or OVER, on start_rise:
  - score1 and score2 cleared to 0; game_over cleared.
  - serve_dir set to 0; ball_reset pulsed.
  - Frame counter loaded with SERVE_FRAMES; state goes to SERVE.
- SERVE:
  - ball_run = 0.
  - Counter decrements on each frame_tick; the frame_tick seen at counter==1 moves the state to PLAY.
  - countdown = 3 while counter > 2·SERVE_FRAMES/3, 2 while counter > SERVE_FRAMES/3, else 1.
- PLAY: ball_run = 1.
  - goal_r only: score1+1, serve_dir set to 1.
  - goal_l only: score2+1, serve_dir set to 0.
  - goal_r and goal_l in the same cycle: no score change, serve_dir unchanged, state goes to POINT.
  - After an increment, if the new score equals WIN_SCORE, state goes to OVER; otherwise POINT.
- POINT:
  - ball_run = 0; counter loaded with POINT_FRAMES on entry.
  - The frame_tick seen at counter==1 pulses ball_reset, loads SERVE_FRAMES and moves the state to SERVE.
- OVER: game_over = 1, ball_run = 0, scores held.
- goal_r and goal_l are ignored in every state except PLAY.
- Scores never exceed WIN_SCORE; there is no wrap.
- start_rise is ignored in SERVE, PLAY, POINT and PAUSE.

## Timing
- Reset values: state=IDLE, score1=0, score2=0, ball_run=0, ball_reset=0, serve_dir=0, game_over=0, countdown=0, counter=0.
- All outputs are registered; none depends combinationally on inputs.
- Transitions take effect on the clock edge that samples the triggering input; outputs reflect the new state one cycle later.
- ball_reset is high for exactly the first cycle of SERVE.
- SERVE lasts exactly SERVE_FRAMES frame_ticks; POINT lasts exactly POINT_FRAMES frame_ticks.
- A frame_tick and a goal in the same cycle in PLAY: the goal is processed; the counter is not used in PLAY.
- reset_n low at any time forces the reset values immediately (asynchronous); a match in progress is abandoned.

## Configuration
- PONG_PAUSE_EN defined:
  - pause_rise in PLAY moves the state to PAUSE; pause_rise in PAUSE returns the state to PLAY.
  - In PAUSE: ball_run=0, goals ignored, scores and serve_dir frozen.
  - start_rise is ignored in PAUSE.
- PONG_PAUSE_EN undefined:
  - pause_btn is ignored and pause_q is not built.
  - Encoding 5 is unreachable; the state never shows 5.

## Test plan
- Reset, then start_btn rises → after 1 cycle: state=1, ball_reset=1 for one cycle, countdown=3. After 40 frame_ticks countdown=2; after 80 countdown=1; after 120 state=2, ball_run=1.
- In PLAY, pulse goal_r → score1=1, serve_dir=1, state=3. After 60 frame_ticks: ball_reset pulse, state=1.
- Drive the score to 7–0, then pulse goal_r → score1=8, game_over=1, state=4. Further goal pulses leave score1=8. start_btn rise → both scores 0, game_over=0, state=1.
- goal_r and goal_l in the same cycle during PLAY → scores unchanged, state=3. A goal pulse during SERVE or POINT → no score change.
- With PONG_PAUSE_EN: pause rise in PLAY → state=5, ball_run=0, goal_l ignored. Second pause rise → state=2. Without the macro, a pause rise leaves state=2.
- reset_n asserted low mid-PLAY at score 3–2 → all outputs return to reset values before the next clk edge.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Pong match-flow controller: idle, serve countdown, play, point pause, game over.
// Optional pause state is built when PONG_PAUSE_EN is defined.
module pong_match_ctrl #(
    parameter int WIN_SCORE    = 8,
    parameter int SERVE_FRAMES = 120,
    parameter int POINT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       goal_r,
    input  logic       goal_l,
    output logic       ball_run,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       game_over,
    output logic [1:0] countdown,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SERVE = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_POINT = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;
`ifdef PONG_PAUSE_EN
    localparam logic [2:0] S_PAUSE = 3'd5;
`endif

    localparam int CNT_MAX = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] SERVE_LD = CW'(SERVE_FRAMES);
    localparam logic [CW-1:0] POINT_LD = CW'(POINT_FRAMES);
    localparam logic [CW-1:0] CD_HI    = CW'(2 * SERVE_FRAMES / 3);
    localparam logic [CW-1:0] CD_LO    = CW'(SERVE_FRAMES / 3);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] counter_q, counter_d;
    logic [3:0]    score1_q, score1_d;
    logic [3:0]    score2_q, score2_d;
    logic          serve_dir_q, serve_dir_d;
    logic          ball_run_q, ball_run_d;
    logic          ball_reset_q, ball_reset_d;
    logic          game_over_q, game_over_d;
    logic [1:0]    countdown_q, countdown_d;
    logic          start_q, start_d;
    logic          start_rise;

`ifdef PONG_PAUSE_EN
    logic pause_q, pause_d;
    logic pause_rise;

    assign pause_d    = pause_btn;
    assign pause_rise = pause_btn & ~pause_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_d;
        end
    end
`else
    logic pause_unused;
    assign pause_unused = pause_btn;
`endif

    assign start_d    = start_btn;
    assign start_rise = start_btn & ~start_q;

    // Next-state and datapath updates for the match sequence.
    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        serve_dir_d  = serve_dir_q;
        ball_reset_d = 1'b0;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    score1_d     = '0;
                    score2_d     = '0;
                    serve_dir_d  = 1'b0;
                    ball_reset_d = 1'b1;
                    counter_d    = SERVE_LD;
                    state_d      = S_SERVE;
                end
            end

            S_SERVE: begin
                if (frame_tick) begin
                    counter_d = counter_q - CNT_ONE;
                    if (counter_q == CNT_ONE) begin
                        state_d = S_PLAY;
                    end
                end
            end

            S_PLAY: begin
                if (goal_r && goal_l) begin
                    counter_d = POINT_LD;
                    state_d   = S_POINT;
                end else if (goal_r) begin
                    score1_d    = score1_q + 4'd1;
                    serve_dir_d = 1'b1;
                    counter_d   = POINT_LD;
                    state_d     = (score1_q + 4'd1 == WIN) ? S_OVER : S_POINT;
                end else if (goal_l) begin
                    score2_d    = score2_q + 4'd1;
                    serve_dir_d = 1'b0;
                    counter_d   = POINT_LD;
                    state_d     = (score2_q + 4'd1 == WIN) ? S_OVER : S_POINT;
                end
`ifdef PONG_PAUSE_EN
                else if (pause_rise) begin
                    state_d = S_PAUSE;
                end
`endif
            end

            S_POINT: begin
                if (frame_tick) begin
                    if (counter_q == CNT_ONE) begin
                        ball_reset_d = 1'b1;
                        counter_d    = SERVE_LD;
                        state_d      = S_SERVE;
                    end else begin
                        counter_d = counter_q - CNT_ONE;
                    end
                end
            end

`ifdef PONG_PAUSE_EN
            S_PAUSE: begin
                if (pause_rise) begin
                    state_d = S_PLAY;
                end
            end
`endif

            default: begin
                state_d   = S_IDLE;
                counter_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so registered outputs line up with state.
    always_comb begin
        ball_run_d  = (state_d == S_PLAY);
        game_over_d = (state_d == S_OVER);
        countdown_d = 2'd0;
        if (state_d == S_SERVE) begin
            if (counter_d > CD_HI) begin
                countdown_d = 2'd3;
            end else if (counter_d > CD_LO) begin
                countdown_d = 2'd2;
            end else begin
                countdown_d = 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            counter_q    <= '0;
            score1_q     <= '0;
            score2_q     <= '0;
            serve_dir_q  <= 1'b0;
            ball_run_q   <= 1'b0;
            ball_reset_q <= 1'b0;
            game_over_q  <= 1'b0;
            countdown_q  <= 2'd0;
            start_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            serve_dir_q  <= serve_dir_d;
            ball_run_q   <= ball_run_d;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
            countdown_q  <= countdown_d;
            start_q      <= start_d;
        end
    end

    assign state      = state_q;
    assign score1     = score1_q;
    assign score2     = score2_q;
    assign serve_dir  = serve_dir_q;
    assign ball_run   = ball_run_q;
    assign ball_reset = ball_reset_q;
    assign game_over  = game_over_q;
    assign countdown  = countdown_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed self-checking bench for pong_match_ctrl with default parameters.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       goal_r = 1'b0;
    logic       goal_l = 1'b0;
    logic       ball_run, ball_reset, serve_dir, game_over;
    logic [3:0] score1, score2;
    logic [1:0] countdown;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    pong_match_ctrl #(.WIN_SCORE(8), .SERVE_FRAMES(120), .POINT_FRAMES(60)) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
        .start_btn(start_btn), .pause_btn(pause_btn),
        .goal_r(goal_r), .goal_l(goal_l),
        .ball_run(ball_run), .ball_reset(ball_reset), .serve_dir(serve_dir),
        .score1(score1), .score2(score2), .game_over(game_over),
        .countdown(countdown), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
    endtask

    // One scored point from PLAY back into PLAY (point pause plus full serve).
    task automatic score_point(input logic right);
        goal_r = right;
        goal_l = ~right;
        step();
        goal_r = 1'b0;
        goal_l = 1'b0;
        tick_frames(60);
        tick_frames(120);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if ({state, score1, score2, ball_run, ball_reset, serve_dir, game_over, countdown} !== 17'd0) begin
            failures++;
            $display("FAIL reset_values got state=%0d s1=%0d s2=%0d run=%b rst=%b dir=%b over=%b cd=%0d exp all 0",
                     state, score1, score2, ball_run, ball_reset, serve_dir, game_over, countdown);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (state !== 3'd0) begin failures++; $display("FAIL idle_after_reset got=%0d exp=0", state); end
    endtask

    task automatic test_serve_countdown();
        press_start();
        checks++;
        if (state !== 3'd1 || ball_reset !== 1'b1 || countdown !== 2'd3 || ball_run !== 1'b0) begin
            failures++;
            $display("FAIL start_to_serve got state=%0d rst=%b cd=%0d run=%b exp 1 1 3 0", state, ball_reset, countdown, ball_run);
        end
        step();
        checks++;
        if (ball_reset !== 1'b0) begin failures++; $display("FAIL ball_reset_width got=%b exp=0", ball_reset); end
        tick_frames(39);
        checks++;
        if (countdown !== 2'd3) begin failures++; $display("FAIL countdown_39 got=%0d exp=3", countdown); end
        tick_frames(1);
        checks++;
        if (countdown !== 2'd2) begin failures++; $display("FAIL countdown_40 got=%0d exp=2", countdown); end
        tick_frames(40);
        checks++;
        if (countdown !== 2'd1) begin failures++; $display("FAIL countdown_80 got=%0d exp=1", countdown); end
        tick_frames(39);
        checks++;
        if (state !== 3'd1) begin failures++; $display("FAIL serve_119 got=%0d exp=1", state); end
        tick_frames(1);
        checks++;
        if (state !== 3'd2 || ball_run !== 1'b1 || countdown !== 2'd0) begin
            failures++;
            $display("FAIL serve_to_play got state=%0d run=%b cd=%0d exp 2 1 0", state, ball_run, countdown);
        end
    endtask

    task automatic test_goal_point();
        goal_r = 1'b1;
        step();
        goal_r = 1'b0;
        checks++;
        if (score1 !== 4'd1 || score2 !== 4'd0 || serve_dir !== 1'b1 || state !== 3'd3 || ball_run !== 1'b0) begin
            failures++;
            $display("FAIL goal_r got s1=%0d s2=%0d dir=%b state=%0d run=%b exp 1 0 1 3 0", score1, score2, serve_dir, state, ball_run);
        end
        goal_l = 1'b1;
        step();
        goal_l = 1'b0;
        checks++;
        if (score2 !== 4'd0 || serve_dir !== 1'b1) begin
            failures++;
            $display("FAIL goal_in_point got s2=%0d dir=%b exp 0 1", score2, serve_dir);
        end
        tick_frames(59);
        checks++;
        if (state !== 3'd3) begin failures++; $display("FAIL point_59 got=%0d exp=3", state); end
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checks++;
        if (state !== 3'd1 || ball_reset !== 1'b1 || countdown !== 2'd3) begin
            failures++;
            $display("FAIL point_to_serve got state=%0d rst=%b cd=%0d exp 1 1 3", state, ball_reset, countdown);
        end
        goal_r = 1'b1;
        step();
        goal_r = 1'b0;
        checks++;
        if (ball_reset !== 1'b0 || score1 !== 4'd1) begin
            failures++;
            $display("FAIL goal_in_serve got rst=%b s1=%0d exp 0 1", ball_reset, score1);
        end
        tick_frames(120);
        checks++;
        if (state !== 3'd2) begin failures++; $display("FAIL back_to_play got=%0d exp=2", state); end
    endtask

    task automatic test_win_over();
        for (int i = 0; i < 6; i++) score_point(1'b1);
        checks++;
        if (score1 !== 4'd7 || state !== 3'd2) begin
            failures++;
            $display("FAIL seven_zero got s1=%0d state=%0d exp 7 2", score1, state);
        end
        goal_r = 1'b1;
        step();
        goal_r = 1'b0;
        checks++;
        if (score1 !== 4'd8 || game_over !== 1'b1 || state !== 3'd4 || ball_run !== 1'b0) begin
            failures++;
            $display("FAIL win got s1=%0d over=%b state=%0d run=%b exp 8 1 4 0", score1, game_over, state, ball_run);
        end
        goal_r = 1'b1;
        step();
        goal_r = 1'b0;
        goal_l = 1'b1;
        step();
        goal_l = 1'b0;
        tick_frames(3);
        checks++;
        if (score1 !== 4'd8 || score2 !== 4'd0 || state !== 3'd4) begin
            failures++;
            $display("FAIL over_hold got s1=%0d s2=%0d state=%0d exp 8 0 4", score1, score2, state);
        end
        press_start();
        checks++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || game_over !== 1'b0 || state !== 3'd1 || serve_dir !== 1'b0 || ball_reset !== 1'b1) begin
            failures++;
            $display("FAIL restart got s1=%0d s2=%0d over=%b state=%0d dir=%b rst=%b exp 0 0 0 1 0 1",
                     score1, score2, game_over, state, serve_dir, ball_reset);
        end
        tick_frames(120);
    endtask

    task automatic test_double_goal();
        press_start();
        checks++;
        if (state !== 3'd2 || ball_reset !== 1'b0) begin
            failures++;
            $display("FAIL start_in_play got state=%0d rst=%b exp 2 0", state, ball_reset);
        end
        goal_r = 1'b1;
        goal_l = 1'b1;
        step();
        goal_r = 1'b0;
        goal_l = 1'b0;
        checks++;
        if (state !== 3'd3 || score1 !== 4'd0 || score2 !== 4'd0 || serve_dir !== 1'b0) begin
            failures++;
            $display("FAIL double_goal got state=%0d s1=%0d s2=%0d dir=%b exp 3 0 0 0", state, score1, score2, serve_dir);
        end
        tick_frames(60);
        tick_frames(120);
    endtask

    task automatic test_pause();
        pause_btn = 1'b1;
        step();
`ifdef PONG_PAUSE_EN
        checks++;
        if (state !== 3'd5 || ball_run !== 1'b0) begin
            failures++;
            $display("FAIL pause_enter got state=%0d run=%b exp 5 0", state, ball_run);
        end
        goal_l = 1'b1;
        step();
        goal_l = 1'b0;
        checks++;
        if (score2 !== 4'd0 || state !== 3'd5) begin
            failures++;
            $display("FAIL goal_in_pause got s2=%0d state=%0d exp 0 5", score2, state);
        end
        pause_btn = 1'b0;
        step();
        pause_btn = 1'b1;
        step();
`endif
        pause_btn = 1'b0;
        step();
        checks++;
        if (state !== 3'd2 || ball_run !== 1'b1) begin
            failures++;
            $display("FAIL pause_exit got state=%0d run=%b exp 2 1", state, ball_run);
        end
    endtask

    task automatic test_async_reset();
        score_point(1'b1);
        score_point(1'b1);
        score_point(1'b0);
        score_point(1'b1);
        score_point(1'b0);
        checks++;
        if (score1 !== 4'd3 || score2 !== 4'd2 || state !== 3'd2 || serve_dir !== 1'b0) begin
            failures++;
            $display("FAIL three_two got s1=%0d s2=%0d state=%0d dir=%b exp 3 2 2 0", score1, score2, state, serve_dir);
        end
        reset_n = 1'b0;
        #2;
        checks++;
        if ({state, score1, score2, ball_run, ball_reset, serve_dir, game_over, countdown} !== 17'd0) begin
            failures++;
            $display("FAIL async_reset got state=%0d s1=%0d s2=%0d run=%b rst=%b dir=%b over=%b cd=%0d exp all 0",
                     state, score1, score2, ball_run, ball_reset, serve_dir, game_over, countdown);
        end
        step();
        reset_n = 1'b1;
        step();
        press_start();
        checks++;
        if (state !== 3'd1 || countdown !== 2'd3) begin
            failures++;
            $display("FAIL start_after_reset got state=%0d cd=%0d exp 1 3", state, countdown);
        end
    endtask

    initial begin
        test_reset();
        test_serve_countdown();
        test_goal_point();
        test_win_over();
        test_double_goal();
        test_pause();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
